// File: rtl/serial_full_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_full_adder_if
//  Description : Operand/result handshake bundle for serial_full_adder.
//                master = operand producer / result consumer,
//                slave  = the adder itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_full_adder_if;
  // operand side
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  // result side
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       parity;
  logic       sign;
  logic       overflow;
  logic       busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, carry, zero, parity, sign, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, carry, zero, parity, sign, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_full_adder
//  Description : 4-bit adder built from a single full-adder cell that is
//                reused for one bit per clock, LSB first. Operands are
//                accepted in IDLE, four SHIFT cycles produce the sum, and the
//                registered result with flags is held in DONE until the
//                consumer takes it.
//  Config      : define SFA_FLAGS_EN to build the zero/parity/sign/overflow
//                flag logic; otherwise those outputs are tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_full_adder (
  input  logic                 clk,
  input  logic                 rst,
  serial_full_adder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] LAST_BIT = 2'd3;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] sum_q, sum_d;
  logic [1:0] cnt_q, cnt_d;
  logic       c_q, c_d;

  // Registered handshake / result outputs
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic [7:0] out_q, out_d;
  logic       carry_q, carry_d;

`ifdef SFA_FLAGS_EN
  logic       zero_q, zero_d;
  logic       parity_q, parity_d;
  logic       sign_q, sign_d;
  logic       overflow_q, overflow_d;
`endif

  // --------------------------------------------------------------------------
  // The one full-adder cell, fed by the bit selected by the counter
  // --------------------------------------------------------------------------
  logic       cell_a;
  logic       cell_b;
  logic       cell_sum;
  logic       cell_carry;
  logic [3:0] sum_next;

  // Full-adder cell and the partial sum with the current bit inserted
  always_comb begin
    cell_a     = a_q[cnt_q];
    cell_b     = b_q[cnt_q];
    cell_sum   = cell_a ^ cell_b ^ c_q;
    cell_carry = (cell_a & cell_b) | (cell_a & c_q) | (cell_b & c_q);
    sum_next          = sum_q;
    sum_next[cnt_q]   = cell_sum;
  end

`ifdef SFA_FLAGS_EN
  // Result flags derived from the completed sum and the latched operands;
  // only consumed on the final SHIFT cycle when sum_next is the full sum.
  logic flag_zero;
  logic flag_parity;
  logic flag_sign;
  logic flag_overflow;

  // Flag evaluation for the finished sum
  always_comb begin
    flag_zero     = (sum_next == 4'd0);
    flag_parity   = ^sum_next;
    flag_sign     = sum_next[3];
    flag_overflow = (a_q[3] == b_q[3]) && (sum_next[3] != a_q[3]);
  end
`endif

  // Next-state and next-output computation for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    out_d       = out_q;
    carry_d     = carry_q;
`ifdef SFA_FLAGS_EN
    zero_d      = zero_q;
    parity_d    = parity_q;
    sign_d      = sign_q;
    overflow_d  = overflow_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Accept only when we have advertised ready; a request arriving on
        // the DONE->IDLE edge sees in_ready still low and is not taken.
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          sum_d      = 4'd0;
          cnt_d      = 2'd0;
          c_d        = 1'b0;
          state_d    = S_SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_SHIFT: begin
        sum_d = sum_next;
        c_d   = cell_carry;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the full result in the same edge
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_d       = {3'b000, cell_carry, sum_next};
          carry_d     = cell_carry;
`ifdef SFA_FLAGS_EN
          zero_d      = flag_zero;
          parity_d    = flag_parity;
          sign_d      = flag_sign;
          overflow_d  = flag_overflow;
`endif
        end
      end

      S_DONE: begin
        // Result is held until the consumer accepts it
        if (out_valid_q && bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register; reset returns to an empty IDLE from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      sum_q       <= 4'd0;
      cnt_q       <= 2'd0;
      c_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= 8'h00;
      carry_q     <= 1'b0;
`ifdef SFA_FLAGS_EN
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      sign_q      <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
`ifdef SFA_FLAGS_EN
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      sign_q      <= sign_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;

`ifdef SFA_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.sign      = sign_q;
  assign bus.overflow  = overflow_q;
`else
  assign bus.zero      = 1'b0;
  assign bus.parity    = 1'b0;
  assign bus.sign      = 1'b0;
  assign bus.overflow  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_full_adder
//  Description : Bench for serial_full_adder. Expected results come from
//                plain integer arithmetic on the operands.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_full_adder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  serial_full_adder_if bus ();

  serial_full_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls unexpectedly
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result: plain integer sums
  task automatic model(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] exp_out, output logic exp_carry,
                       output logic [3:0] exp_flags);
    int total;
    int sa;
    int sb;
    int ssum;
    logic [3:0] s4;
    total     = int'(a) + int'(b);
    s4        = total[3:0];
    exp_out   = 8'(total % 32);
    exp_carry = (total >= 16);
    sa        = (a >= 8) ? int'(a) - 16 : int'(a);
    sb        = (b >= 8) ? int'(b) - 16 : int'(b);
    ssum      = sa + sb;
`ifdef SFA_FLAGS_EN
    exp_flags[3] = (total % 16 == 0);          // zero
    exp_flags[2] = ($countones(s4) % 2 == 1);  // parity
    exp_flags[1] = (total % 16 >= 8);          // sign
    exp_flags[0] = (ssum > 7) || (ssum < -8);  // overflow
`else
    exp_flags = 4'b0000;
`endif
  endtask

  task automatic check_result(input string tag, input logic [7:0] eo, input logic ec, input logic [3:0] ef);
    check_value({tag, "_out"},   bus.out, eo);
    check_value({tag, "_carry"}, bus.carry, ec);
    check_value({tag, "_flags"}, {bus.zero, bus.parity, bus.sign, bus.overflow}, ef);
  endtask

  // One full transaction with bp cycles of result backpressure; junk
  // operands are offered while busy and must be ignored.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int bp);
    logic [7:0] eo;
    logic       ec;
    logic [3:0] ef;
    int         waited;
    model(a, b, eo, ec, ef);
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      step();
      waited++;
    end
    check_value("idle_in_ready", bus.in_ready, 1);
    check_value("idle_busy", bus.busy, 0);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    step();  // accepting edge
    for (int i = 0; i < 4; i++) begin
      check_value("shift_out_valid", bus.out_valid, 0);
      check_value("shift_in_ready", bus.in_ready, 0);
      check_value("shift_busy", bus.busy, 1);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = 4'($urandom);
      bus.b        = 4'($urandom);
      step();
    end
    check_value("done_out_valid", bus.out_valid, 1);
    check_value("done_in_ready", bus.in_ready, 0);
    check_result("done", eo, ec, ef);
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 4'($urandom);
      bus.b        = 4'($urandom);
      step();
      check_value("hold_out_valid", bus.out_valid, 1);
      check_value("hold_in_ready", bus.in_ready, 0);
      check_value("hold_out", bus.out, eo);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;  // offered on the handoff edge: must not be taken
    bus.a         = 4'($urandom);
    bus.b         = 4'($urandom);
    step();
    check_value("release_out_valid", bus.out_valid, 0);
    check_value("release_busy", bus.busy, 0);
    check_value("release_in_ready", bus.in_ready, 1);
    check_result("held_after", eo, ec, ef);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_out_valid"}, bus.out_valid, 0);
    check_value({tag, "_busy"}, bus.busy, 0);
    check_value({tag, "_in_ready"}, bus.in_ready, 1);
    check_result(tag, 8'h00, 1'b0, 4'b0000);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 4'd0;
    bus.b         = 4'd0;
    bus.out_ready = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    // Directed cases
    run_txn(4'd3,  4'd1, 0);
    run_txn(4'd15, 4'd1, 0);
    run_txn(4'd7,  4'd1, 1);
    run_txn(4'd8,  4'd8, 0);
    run_txn(4'd5,  4'd6, 3);
    run_txn(4'd0,  4'd0, 0);
    run_txn(4'd15, 4'd15, 2);

    // Reset on the 2nd SHIFT edge discards the transaction
    bus.in_valid = 1'b1;
    bus.a        = 4'd9;
    bus.b        = 4'd9;
    step();              // accept
    bus.in_valid = 1'b0;
    step();              // 1st SHIFT edge
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();              // 2nd SHIFT edge, reset wins
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_reset_state("rst_shift");
    for (int i = 0; i < 6; i++) begin
      step();
      check_value("rst_shift_no_valid", bus.out_valid, 0);
    end
    run_txn(4'd2, 4'd2, 0);

    // Reset while holding a result in DONE
    bus.in_valid = 1'b1;
    bus.a        = 4'd6;
    bus.b        = 4'd7;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_value("pre_rst_done_valid", bus.out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_done");
    step();
    check_value("rst_done_no_valid", bus.out_valid, 0);

    // Randomized operands and backpressure
    for (int n = 0; n < 40; n++) begin
      run_txn(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_full_adder.md
SERIAL_FULL_ADDER -- requirements
Module: serial_full_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept operands (IDLE only).
REQ-006 a  input  4  unsigned/two's-complement addend A.
REQ-007 b  input  4  unsigned/two's-complement addend B.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out  output  8  out[3:0]=sum, out[4]=carry, out[7:5]=0.
REQ-011 carry  output  1  carry out of bit 3.
REQ-012 zero, parity, sign, overflow  output  1 each  result flags.
REQ-013 busy  output  1  high in SHIFT or DONE.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready at an edge, latch a, b, clear carry register and 2-bit bit counter, go to SHIFT.
REQ-016 SHIFT: one full-adder cell per cycle, LSB first; sum[i]=a[i]^b[i]^c, c<=majority(a[i],b[i],c); counter increments each edge.
REQ-017 After bit 3 is computed (4th SHIFT edge) the FSM SHALL enter DONE; out_valid rises exactly 4 edges after the accepting edge.
REQ-018 DONE: out_valid=1; out and flags held stable until out_valid&out_ready at an edge, then IDLE.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; operands presented then are ignored and not queued.
REQ-020 in_valid during the DONE->IDLE handoff edge SHALL NOT be accepted; first accept is one edge after IDLE entry (min 6-cycle throughput with out_ready=1).
REQ-021 carry = final carry register; out[4] equals carry.
REQ-022 zero = (sum[3:0]==0); parity = XOR of sum[3:0] (1 = odd count of ones); sign = sum[3].
REQ-023 overflow = (a[3]==b[3]) && (sum[3]!=a[3]) using latched operands.
REQ-024 out and flags SHALL hold previous result values outside DONE; they are only guaranteed meaningful when out_valid=1.
REQ-025 Wrap-around: 4-bit sum is modulo 16; excess reported only via carry.

Reset
REQ-026 rst=1 SHALL force IDLE, out_valid=0, busy=0, in_ready=1 on the next edge, from any state.
REQ-027 Reset SHALL clear out to 8'h00, carry, zero, parity, sign, overflow to 0, operand, counter and carry registers to 0.
REQ-028 Reset mid-SHIFT or mid-DONE SHALL discard the transaction; no out_valid pulse follows.
REQ-029 rst takes priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 Macro SFA_FLAGS_EN defined: zero, parity, sign, overflow computed per REQ-022/023.
REQ-031 SFA_FLAGS_EN undefined: zero, parity, sign, overflow tied to 0, no flag logic generated; out, carry and handshake unchanged.

Verification
REQ-032 a=3,b=1 accept -> after 4 edges out_valid=1, out=8'h04, carry=0, zero=0, parity=1, sign=0, overflow=0.
REQ-033 a=15,b=1 -> out=8'h10, carry=1, zero=1, parity=0, sign=0, overflow=0.
REQ-034 a=7,b=1 -> out=8'h08, carry=0, sign=1, parity=1, overflow=1; a=8,b=8 -> out=8'h10, carry=1, zero=1, overflow=1.
REQ-035 Backpressure: a=5,b=6, out_ready=0 for 3 cycles in DONE -> out=8'h0B stable, out_valid held, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-036 rst=1 on 2nd SHIFT edge of a=9,b=9 -> IDLE, out=8'h00, no out_valid; next transaction a=2,b=2 -> out=8'h04.
REQ-037 SFA_FLAGS_EN undefined, a=7,b=1 -> out=8'h08, carry=0, all four flags 0.
